gpr_writeback: RTL and testbench

Writeback-side controller that drives the write port of the 64-bit general-purpose register file. It accepts results from the ALU and the load/store unit over valid/ready handshakes and buffers load returns in a small FIFO. Each cycle it arbitrates one result onto a registered write port (write_en / write_rd_addr / rd_data). It also keeps a per-register busy scoreboard so the issue stage can stall on RAW hazards.

---
 rtl/gpr_writeback_if.sv | 51 +++++
 rtl/gpr_writeback.sv | 141 ++++++++++++++
 tb/tb_gpr_writeback.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_writeback_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpr_writeback_if
//   Result handshakes, hazard query and register-file write port of the
//   GPR writeback controller.
//   Revision: 1.0
// ----------------------------------------------------------------------------
interface gpr_writeback_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_rs1_addr;
  logic [4:0]      chk_rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            write_en;
  logic [4:0]      write_rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            wb_pending;

  // Producer / issue side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, chk_rs1_addr, chk_rs2_addr,
    input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
    input  write_en, write_rd_addr, rd_data, wb_pending
  );

  // Writeback controller side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, chk_rs1_addr, chk_rs2_addr,
    output alu_ready, lsu_ready, rs1_busy, rs2_busy,
    output write_en, write_rd_addr, rd_data, wb_pending
  );
endinterface
`default_nettype wire

// File: rtl/gpr_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpr_writeback
//   Arbitrates ALU results and buffered load returns onto a registered GPR
//   write port, and tracks per-register busy bits for RAW hazard stalls.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module gpr_writeback #(
  parameter int XLEN      = 64,
  parameter int LSU_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  gpr_writeback_if.slave bus
);

  localparam int               c_PTR_W    = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(LSU_DEPTH);
  localparam logic [c_PTR_W:0] c_CNT_ONE  = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  // Load-return FIFO
  logic [4:0]         r_fifo_rd   [LSU_DEPTH];
  logic [XLEN-1:0]    r_fifo_data [LSU_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  // Write port
  logic               r_write_en;
  logic [4:0]         r_write_rd;
  logic [XLEN-1:0]    r_write_data;

  // Scoreboard; x0 is never busy so it has no storage
  logic [31:1]        r_busy;
  logic [31:0]        w_busy_all;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_sel_valid;
  logic [4:0]         w_sel_rd;
  logic [XLEN-1:0]    w_sel_data;

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.lsu_valid & ~w_full;

  // A full FIFO takes priority over the ALU so loads cannot starve forever.
  always_comb begin
    w_pop       = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_rd    = 5'd0;
    w_sel_data  = '0;
    if (w_full || (!bus.alu_valid && !w_empty)) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_rd    = r_fifo_rd[r_rd_ptr];
      w_sel_data  = r_fifo_data[r_rd_ptr];
    end else if (bus.alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.alu_rd;
      w_sel_data  = bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= bus.lsu_rd;
      r_fifo_data[r_wr_ptr] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Results to x0 still complete their handshake but never strobe the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write_en   <= 1'b0;
      r_write_rd   <= 5'd0;
      r_write_data <= '0;
    end else begin
      r_write_en <= w_sel_valid && (w_sel_rd != 5'd0);
      if (w_sel_valid) begin
        r_write_rd   <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
    end
  end

  // Set has priority over clear: a newly issued producer owns the register.
  generate
    for (genvar i = 1; i < 32; i++) begin : g_busy
      logic w_set;
      logic w_clr;
      assign w_set = bus.iss_valid && (bus.iss_rd == 5'(i));
      assign w_clr = r_write_en && (r_write_rd == 5'(i));
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy[i] <= 1'b0;
        end else if (w_set) begin
          r_busy[i] <= 1'b1;
        end else if (w_clr) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_busy_all = {r_busy, 1'b0};

  assign bus.alu_ready     = ~w_full;
  assign bus.lsu_ready     = ~w_full;
  assign bus.rs1_busy      = w_busy_all[bus.chk_rs1_addr];
  assign bus.rs2_busy      = w_busy_all[bus.chk_rs2_addr];
  assign bus.wb_pending    = |r_busy;
  assign bus.write_en      = r_write_en;
  assign bus.write_rd_addr = r_write_rd;
  assign bus.rd_data       = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gpr_writeback
//   Directed and random checks of gpr_writeback (FIFO depths 2 and 4).
//   Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpr_writeback;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            alu_valid, lsu_valid, iss_valid;
  logic [4:0]      alu_rd, lsu_rd, iss_rd, chk1, chk2;
  logic [XLEN-1:0] alu_data, lsu_data;

  gpr_writeback_if #(.XLEN(XLEN)) bus_a ();
  gpr_writeback_if #(.XLEN(XLEN)) bus_b ();

  gpr_writeback #(.XLEN(XLEN), .LSU_DEPTH(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  gpr_writeback #(.XLEN(XLEN), .LSU_DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.alu_valid = alu_valid;    assign bus_b.alu_valid = alu_valid;
  assign bus_a.alu_rd = alu_rd;          assign bus_b.alu_rd = alu_rd;
  assign bus_a.alu_data = alu_data;      assign bus_b.alu_data = alu_data;
  assign bus_a.lsu_valid = lsu_valid;    assign bus_b.lsu_valid = lsu_valid;
  assign bus_a.lsu_rd = lsu_rd;          assign bus_b.lsu_rd = lsu_rd;
  assign bus_a.lsu_data = lsu_data;      assign bus_b.lsu_data = lsu_data;
  assign bus_a.iss_valid = iss_valid;    assign bus_b.iss_valid = iss_valid;
  assign bus_a.iss_rd = iss_rd;          assign bus_b.iss_rd = iss_rd;
  assign bus_a.chk_rs1_addr = chk1;      assign bus_b.chk_rs1_addr = chk1;
  assign bus_a.chk_rs2_addr = chk2;      assign bus_b.chk_rs2_addr = chk2;

  // {alu_ready, lsu_ready, rs1_busy, rs2_busy, wb_pending, write_en, addr, data}
  logic [74:0] obs_a, obs_b;
  assign obs_a = {bus_a.alu_ready, bus_a.lsu_ready, bus_a.rs1_busy, bus_a.rs2_busy,
                  bus_a.wb_pending, bus_a.write_en, bus_a.write_rd_addr, bus_a.rd_data};
  assign obs_b = {bus_b.alu_ready, bus_b.lsu_ready, bus_b.rs1_busy, bus_b.rs2_busy,
                  bus_b.wb_pending, bus_b.write_en, bus_b.write_rd_addr, bus_b.rd_data};

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of pending loads, a busy set, the write-port value
  int          depth_m [2] = '{2, 4};
  logic [68:0] q0 [$];
  logic [68:0] q1 [$];
  bit          busy_m [2][32];
  bit          wen_m  [2];
  logic [4:0]  wrd_m  [2];
  logic [63:0] wdat_m [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) busy_m[k][r] = 1'b0;
      wen_m[k]  = 1'b0;
      wrd_m[k]  = 5'd0;
      wdat_m[k] = 64'd0;
    end
  endtask

  // Compare one instance against the model, then advance the model by one edge.
  task automatic model_cycle(input int k);
    logic [68:0] q [$];
    logic [74:0] o;
    string       nm;
    bit          full, any, sel_v, sel_head;
    logic [4:0]  sel_rd;
    logic [63:0] sel_d;
    if (k == 0) begin q = q0; o = obs_a; nm = "d2"; end
    else        begin q = q1; o = obs_b; nm = "d4"; end
    full = (q.size() == depth_m[k]);
    any  = 1'b0;
    for (int r = 1; r < 32; r++) any |= busy_m[k][r];
    chk({nm, ".alu_ready"},  64'(o[74]), 64'(!full));
    chk({nm, ".lsu_ready"},  64'(o[73]), 64'(!full));
    chk({nm, ".rs1_busy"},   64'(o[72]), 64'((chk1 != 0) && busy_m[k][chk1]));
    chk({nm, ".rs2_busy"},   64'(o[71]), 64'((chk2 != 0) && busy_m[k][chk2]));
    chk({nm, ".wb_pending"}, 64'(o[70]), 64'(any));
    chk({nm, ".write_en"},   64'(o[69]), 64'(wen_m[k]));
    chk({nm, ".write_rd"},   64'(o[68:64]), 64'(wrd_m[k]));
    chk({nm, ".rd_data"},    o[63:0], wdat_m[k]);

    sel_head = full || (!alu_valid && q.size() > 0);
    sel_v    = sel_head || alu_valid;
    sel_rd   = alu_rd;
    sel_d    = alu_data;
    if (sel_head) begin
      sel_rd = q[0][68:64];
      sel_d  = q[0][63:0];
      void'(q.pop_front());
    end
    if (lsu_valid && !full) q.push_back({lsu_rd, lsu_data});
    if (wen_m[k]) busy_m[k][wrd_m[k]] = 1'b0;
    if (iss_valid && iss_rd != 0) busy_m[k][iss_rd] = 1'b1;
    wen_m[k] = sel_v && (sel_rd != 0);
    if (sel_v) begin
      wrd_m[k]  = sel_rd;
      wdat_m[k] = sel_d;
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask

  // Entered 1ns after a rising edge with inputs already driven.
  task automatic tick();
    #1;
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rd = 0; chk1 = 0; chk2 = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.write_en", 64'(bus_a.write_en), 64'd0);
    chk("reset.rd_data", bus_a.rd_data, 64'd0);
    chk("reset.lsu_ready", 64'(bus_a.lsu_ready), 64'd1);
    rst = 1'b0;

    // ALU writeback clears the busy bit one edge after the write strobe
    iss_valid = 1; iss_rd = 5;
    tick();
    iss_valid = 0; chk1 = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    #1 chk("alu.busy_before", 64'(bus_a.rs1_busy), 64'd1);
    tick();
    alu_valid = 0;
    #1;
    chk("alu.write_en", 64'(bus_a.write_en), 64'd1);
    chk("alu.write_rd", 64'(bus_a.write_rd_addr), 64'd5);
    chk("alu.rd_data", bus_a.rd_data, 64'h1234);
    chk("alu.busy_held", 64'(bus_a.rs1_busy), 64'd1);
    tick();
    #1 chk("alu.busy_cleared", 64'(bus_a.rs1_busy), 64'd0);

    // ALU stream fills the FIFO; loads then drain in order
    alu_valid = 1; alu_rd = 13; alu_data = 64'h13;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 64'hAA;
    tick();
    alu_rd = 14; alu_data = 64'h14; lsu_rd = 8; lsu_data = 64'hBB;
    tick();
    lsu_valid = 0; alu_rd = 15; alu_data = 64'h15;
    #1;
    chk("fill.lsu_ready", 64'(bus_a.lsu_ready), 64'd0);
    chk("fill.alu_ready", 64'(bus_a.alu_ready), 64'd0);
    tick();
    alu_valid = 0;
    #1;
    chk("drain.first_rd", 64'(bus_a.write_rd_addr), 64'd7);
    chk("drain.first_data", bus_a.rd_data, 64'hAA);
    chk("drain.alu_ready_back", 64'(bus_a.alu_ready), 64'd1);
    tick();
    #1;
    chk("drain.second_rd", 64'(bus_a.write_rd_addr), 64'd8);
    chk("drain.second_data", bus_a.rd_data, 64'hBB);

    // Results to x0 are consumed silently; issuing x0 marks nothing busy
    alu_valid = 1; alu_rd = 0; alu_data = 64'h55;
    #1 chk("x0.alu_ready", 64'(bus_a.alu_ready), 64'd1);
    tick();
    alu_valid = 0; iss_valid = 1; iss_rd = 0;
    #1 chk("x0.write_en", 64'(bus_a.write_en), 64'd0);
    tick();
    iss_valid = 0;
    #1 chk("x0.wb_pending", 64'(bus_a.wb_pending), 64'd0);

    // Re-issue of x9 on the same edge its old result is written: stays busy
    iss_valid = 1; iss_rd = 9;
    tick();
    iss_valid = 0; alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
    tick();
    alu_valid = 0; iss_valid = 1; iss_rd = 9;
    #1 chk("reissue.write_en", 64'(bus_a.write_en), 64'd1);
    tick();
    iss_valid = 0; chk1 = 9;
    #1;
    chk("reissue.rs1_busy", 64'(bus_a.rs1_busy), 64'd1);
    chk("reissue.wb_pending", 64'(bus_a.wb_pending), 64'd1);

    // Asynchronous reset mid-cycle with a full FIFO and a live write strobe
    alu_valid = 1; alu_rd = 3; alu_data = 64'h33;
    lsu_valid = 1; lsu_rd = 11; lsu_data = 64'h11;
    tick();
    lsu_rd = 12; lsu_data = 64'h12;
    tick();
    #1;
    chk("areset.pre_write_en", 64'(bus_a.write_en), 64'd1);
    chk("areset.pre_full", 64'(bus_a.lsu_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("areset.write_en", 64'(bus_a.write_en), 64'd0);
    chk("areset.write_rd", 64'(bus_a.write_rd_addr), 64'd0);
    chk("areset.rd_data", bus_a.rd_data, 64'd0);
    chk("areset.alu_ready", 64'(bus_a.alu_ready), 64'd1);
    chk("areset.lsu_ready", 64'(bus_a.lsu_ready), 64'd1);
    chk("areset.wb_pending", 64'(bus_a.wb_pending), 64'd0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    #1 chk("areset.no_stale", 64'(bus_a.write_en), 64'd0);

    // Random traffic against both FIFO depths
    for (int n = 0; n < 800; n++) begin
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_rd    = 5'($urandom_range(0, 15));
      alu_data  = {$urandom, $urandom};
      lsu_valid = ($urandom_range(0, 9) < 5);
      lsu_rd    = 5'($urandom_range(0, 15));
      lsu_data  = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 9) < 4);
      iss_rd    = 5'($urandom_range(0, 15));
      chk1      = 5'($urandom_range(0, 15));
      chk2      = 5'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
